// File: rtl/uart_rx_os16.sv
// uart_rx_os16 -- 16x-oversampled UART receiver (8N1 by default, LSB first).
//
// Bit timing comes from baud_tick, a one-cycle enable pulse issued OS_RATE
// times per bit period by the baud divider. The whole block runs on pll_clk.
// The FSM waits for a falling edge on the synchronized line, re-checks it in
// the middle of the start bit, then samples every data bit (and the stop
// bit) at mid-bit.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the payload and the stop bit, along with the parity_err output.
//
// Ports:
//   pll_clk    in   system clock
//   n_rst      in   asynchronous active-low reset
//   baud_tick  in   oversample enable, OS_RATE pulses per bit
//   rx         in   asynchronous serial line, idle high
//   data_out   out  last received payload; holds until the next frame ends
//   data_valid out  1-cycle pulse: frame good, data_out valid
//   frame_err  out  1-cycle pulse: stop bit sampled low
//   parity_err out  (UART_RX_PARITY_EN only) 1-cycle pulse alongside
//                   data_valid/frame_err when even parity fails
//   busy       out  FSM not in IDLE
module uart_rx_os16 #(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16
) (
  input  logic                 pll_clk,
  input  logic                 n_rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int TW = $clog2(OS_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OS_RATE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  assign busy = (state != S_IDLE);

  always_ff @(posedge pll_clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        // Edge detection is not tick-gated so the start-bit phase error is
        // bounded by the tick period, not by an extra tick of wait.
        S_IDLE: begin
          if (!rx_s) begin
            state    <= S_START;
            tick_cnt <= '0;
          end
        end
        S_START: begin
          if (baud_tick) begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              // A line that is high again at mid-start was a glitch.
              state    <= rx_s ? S_IDLE : S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (baud_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              data_out <= shreg;
`ifdef UART_RX_PARITY_EN
              parity_err <= ^{shreg, par_bit};
`endif
              // Leave mid-stop-bit so a following start edge is not missed.
              if (rx_s) begin
                data_valid <= 1'b1;
                state      <= S_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= S_BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        // Held-low line: wait for idle so it is not decoded as more frames.
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: baud_tick every 4 pll_clk cycles,
// so one bit period is 64 cycles. A monitor records every output pulse into
// a queue, and each frame's expected pulse is derived from the bits sent.
module tb_uart_rx_os16;

  localparam int BIT = 64;

  logic       pll_clk = 1'b0;
  logic       n_rst;
  logic       baud_tick = 1'b0;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_os16 dut (
    .pll_clk   (pll_clk),
    .n_rst     (n_rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 pll_clk = ~pll_clk;

  int tdiv = 0;
  always @(negedge pll_clk) begin
    tdiv      = (tdiv + 1) % 4;
    baud_tick = (tdiv == 0);
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       dv, fe, pe;
  } ev_t;
  ev_t evq[$];

  always @(negedge pll_clk) begin
    if (n_rst === 1'b1 && (data_valid === 1'b1 || frame_err === 1'b1)) begin
      ev_t e;
      chk("valid_ferr_exclusive", {31'b0, data_valid & frame_err}, 32'd0);
      e.d  = data_out;
      e.dv = data_valid;
      e.fe = frame_err;
`ifdef UART_RX_PARITY_EN
      e.pe = parity_err;
`else
      e.pe = 1'b0;
`endif
      evq.push_back(e);
    end
  end

  task automatic hold(input logic v, input int cyc);
    rx = v;
    repeat (cyc) @(negedge pll_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    hold(par, BIT);
`else
    if (par) begin end
`endif
    hold(stop, BIT);
  endtask

  // Exactly one pulse expected for the frame just sent.
  task automatic check_frame(input string nm, input logic dv, input logic fe,
                             input logic pe, input logic [7:0] d);
    chk({nm, "_npulse"}, evq.size(), 1);
    if (evq.size() >= 1) begin
      ev_t e;
      e = evq.pop_front();
      chk({nm, "_valid"}, {31'b0, e.dv}, {31'b0, dv});
      chk({nm, "_ferr"},  {31'b0, e.fe}, {31'b0, fe});
      chk({nm, "_data"},  {24'b0, e.d},  {24'b0, d});
`ifdef UART_RX_PARITY_EN
      chk({nm, "_perr"},  {31'b0, e.pe}, {31'b0, pe});
`else
      if (pe) begin end
`endif
    end
    chk({nm, "_data_hold"}, {24'b0, data_out}, {24'b0, d});
    evq.delete();
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop, par;
    int         gap;   // idle bit times after the frame; 0 = back-to-back
    logic       dv, fe, pe;
  } vec_t;

  initial begin
    vec_t vt[6];
    vt[0] = '{8'hA5, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vt[1] = '{8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'hFF, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vt[3] = '{8'h03, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b1};
    vt[4] = '{8'h03, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{8'hC3, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0};

    rx    = 1'b1;
    n_rst = 1'b0;
    repeat (5) @(negedge pll_clk);
    chk("rst_data_out",   {24'b0, data_out}, 32'h0);
    chk("rst_data_valid", {31'b0, data_valid}, 32'h0);
    chk("rst_frame_err",  {31'b0, frame_err}, 32'h0);
    chk("rst_busy",       {31'b0, busy}, 32'h0);
    n_rst = 1'b1;
    hold(1'b1, 20);

    // Low for ~5 ticks, shorter than half a bit: must be treated as a glitch.
    hold(1'b0, 20);
    hold(1'b1, 100);
    chk("glitch_npulse", evq.size(), 0);
    chk("glitch_data",   {24'b0, data_out}, 32'h0);
    chk("glitch_busy",   {31'b0, busy}, 32'h0);
    evq.delete();

    foreach (vt[i]) begin
      send_frame(vt[i].d, vt[i].stop, vt[i].par);
      check_frame($sformatf("vec%0d", i), vt[i].dv, vt[i].fe, vt[i].pe, vt[i].d);
      hold(1'b1, vt[i].gap * BIT);
      if (vt[i].gap > 0) chk($sformatf("vec%0d_idle_busy", i), {31'b0, busy}, 32'h0);
    end

    // Bad stop bit followed by a held-low line.
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 3 * BIT);
    check_frame("break", 1'b0, 1'b1, 1'b0, 8'h3C);
    chk("break_busy_low_line", {31'b0, busy}, 32'h1);
    hold(1'b1, 16);
    chk("break_npulse_after", evq.size(), 0);
    chk("break_busy_released", {31'b0, busy}, 32'h0);

    // Reset during data bit 4 of 0x81 discards the partial byte.
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(((8'h81 >> i) & 8'h1) != 0, BIT);
    hold(1'b0, 20);
    n_rst = 1'b0;
    hold(1'b0, 10);
    chk("midrst_data_out", {24'b0, data_out}, 32'h0);
    chk("midrst_busy",     {31'b0, busy}, 32'h0);
    n_rst = 1'b1;
    hold(1'b1, 2 * BIT);
    chk("midrst_npulse", evq.size(), 0);
    evq.delete();
    send_frame(8'h7E, 1'b1, 1'b0);
    check_frame("after_rst", 1'b1, 1'b0, 1'b0, 8'h7E);
    hold(1'b1, BIT);

    // Random frames against a reference derived from the line bits.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      logic       stop, par, pe;
      int         gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = 1'($urandom);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      pe   = (($countones(d) + int'(par)) % 2) != 0;
      send_frame(d, stop, par);
      check_frame($sformatf("rnd%0d", k), stop, !stop, pe, d);
      hold(1'b1, gap * BIT);
      if (gap > 0) chk($sformatf("rnd%0d_idle_busy", k), {31'b0, busy}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
